// File: rtl/sha256_nonce_sched.sv
// Nonce-range scheduler for a single-block SHA-256 core: stops on the first digest <= target.
// Optional macro SHA256_SCHED_STATS_EN adds the hash_count statistics output.
module sha256_nonce_sched #(
    parameter int NONCE_POS = 0,
    parameter int TIMEOUT   = 200,
    parameter int TMO_W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] cfg_block,
    input  logic [31:0]  cfg_nonce_lo,
    input  logic [31:0]  cfg_nonce_hi,
    input  logic [255:0] cfg_target,
    input  logic         go,
    input  logic         abort,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         timeout_err,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_digest,
`ifdef SHA256_SCHED_STATS_EN
    output logic [31:0]  hash_count,
`endif
    output logic         core_rst,
    output logic         core_start,
    output logic [511:0] core_data_in,
    input  logic         core_done,
    input  logic [255:0] core_digest
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    state_t         state_r;
    state_t         fsm_next_s;
    state_t         next_state_s;

    logic [511:0]   blk_r;
    logic [31:0]    hi_r;
    logic [255:0]   target_r;
    logic [31:0]    nonce_r;
    logic [255:0]   digest_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [511:0]   core_data_r;

    logic           busy_r;
    logic           found_r;
    logic           exhausted_r;
    logic           timeout_err_r;
    logic [31:0]    found_nonce_r;
    logic [255:0]   found_digest_r;
    logic           core_rst_r;
    logic           core_start_r;

    logic           go_acc_s;
    logic           abort_s;
    logic           hit_s;
    logic           last_s;
    logic           tmo_hit_s;
    logic           tmo_s;
    logic [31:0]    nonce_inc_s;

    function automatic logic [511:0] insert_nonce(input logic [511:0] blk, input logic [31:0] n);
        logic [511:0] r;
        r = blk;
        r[NONCE_POS +: 32] = n;
        return r;
    endfunction

    // Event decode shared by the FSM and the output/datapath registers
    always_comb begin
        go_acc_s    = (state_r == ST_IDLE) && go;
        abort_s     = (state_r != ST_IDLE) && abort;
        hit_s       = (digest_r <= target_r);
        last_s      = (nonce_r == hi_r);
        tmo_hit_s   = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
        tmo_s       = (state_r == ST_WAIT) && !core_done && tmo_hit_s;
        nonce_inc_s = nonce_r + 32'd1;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go) fsm_next_s = ST_CLR;
                else    fsm_next_s = ST_IDLE;
            end
            ST_CLR:  fsm_next_s = ST_LOAD;
            ST_LOAD: fsm_next_s = ST_WAIT;
            ST_WAIT: begin
                if (core_done)      fsm_next_s = ST_CHECK;
                else if (tmo_hit_s) fsm_next_s = ST_IDLE;
                else                fsm_next_s = ST_WAIT;
            end
            ST_CHECK: begin
                if (hit_s || last_s) fsm_next_s = ST_IDLE;
                else                 fsm_next_s = ST_CLR;
            end
            default: fsm_next_s = ST_IDLE;
        endcase
        next_state_s = abort_s ? ST_IDLE : fsm_next_s;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= next_state_s;
    end

    // Captured configuration, current nonce, block to the core, digest latch and timeout counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_r       <= 512'd0;
            hi_r        <= 32'd0;
            target_r    <= 256'd0;
            nonce_r     <= 32'd0;
            core_data_r <= 512'd0;
            digest_r    <= 256'd0;
            tmo_cnt_r   <= '0;
        end else begin
            if (go_acc_s) begin
                blk_r       <= cfg_block;
                hi_r        <= cfg_nonce_hi;
                target_r    <= cfg_target;
                nonce_r     <= cfg_nonce_lo;
                core_data_r <= insert_nonce(cfg_block, cfg_nonce_lo);
            end else if ((state_r == ST_CHECK) && (next_state_s == ST_CLR)) begin
                nonce_r     <= nonce_inc_s;
                core_data_r <= insert_nonce(blk_r, nonce_inc_s);
            end
            if ((state_r == ST_WAIT) && core_done) digest_r <= core_digest;
            // Counts cycles since the start pulse, the start cycle itself being 1
            if (state_r == ST_LOAD)      tmo_cnt_r <= TMO_W'(1);
            else if (state_r == ST_WAIT) tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Registered status flags and core handshake strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r         <= 1'b0;
            found_r        <= 1'b0;
            exhausted_r    <= 1'b0;
            timeout_err_r  <= 1'b0;
            found_nonce_r  <= 32'd0;
            found_digest_r <= 256'd0;
            core_rst_r     <= 1'b1;
            core_start_r   <= 1'b0;
        end else begin
            busy_r       <= (next_state_s != ST_IDLE);
            core_rst_r   <= (next_state_s == ST_CLR) || abort_s;
            core_start_r <= (next_state_s == ST_LOAD);
            if (go_acc_s) begin
                found_r       <= 1'b0;
                exhausted_r   <= 1'b0;
                timeout_err_r <= 1'b0;
            end else if (abort_s) begin
                found_nonce_r <= nonce_r;
            end else if (tmo_s) begin
                timeout_err_r <= 1'b1;
                found_nonce_r <= nonce_r;
            end else if ((state_r == ST_CHECK) && hit_s) begin
                found_r        <= 1'b1;
                found_nonce_r  <= nonce_r;
                found_digest_r <= digest_r;
            end else if ((state_r == ST_CHECK) && last_s) begin
                exhausted_r   <= 1'b1;
                found_nonce_r <= nonce_r;
            end
        end
    end

`ifdef SHA256_SCHED_STATS_EN
    logic [31:0] hash_count_r;

    // Saturating count of completed hash comparisons in the current search
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hash_count_r <= 32'd0;
        end else if (go_acc_s) begin
            hash_count_r <= 32'd0;
        end else if ((state_r == ST_CHECK) && (hash_count_r != 32'hFFFF_FFFF)) begin
            hash_count_r <= hash_count_r + 32'd1;
        end
    end

    assign hash_count = hash_count_r;
`endif

    assign busy         = busy_r;
    assign found        = found_r;
    assign exhausted    = exhausted_r;
    assign timeout_err  = timeout_err_r;
    assign found_nonce  = found_nonce_r;
    assign found_digest = found_digest_r;
    assign core_rst     = core_rst_r;
    assign core_start   = core_start_r;
    assign core_data_in = core_data_r;

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Scoreboard bench for sha256_nonce_sched: a behavioural core model plus a range-walking reference.
`timescale 1ns/1ps
module tb_sha256_nonce_sched;

    localparam int NONCE_POS = 96;
    localparam int TIMEOUT   = 200;
    localparam int TMO_W     = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] cfg_block;
    logic [31:0]  cfg_nonce_lo;
    logic [31:0]  cfg_nonce_hi;
    logic [255:0] cfg_target;
    logic         go;
    logic         abort;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         timeout_err;
    logic [31:0]  found_nonce;
    logic [255:0] found_digest;
`ifdef SHA256_SCHED_STATS_EN
    logic [31:0]  hash_count;
`endif
    logic         core_rst;
    logic         core_start;
    logic [511:0] core_data_in;
    logic         core_done;
    logic [255:0] core_digest;

    sha256_nonce_sched #(.NONCE_POS(NONCE_POS), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_block(cfg_block), .cfg_nonce_lo(cfg_nonce_lo), .cfg_nonce_hi(cfg_nonce_hi),
        .cfg_target(cfg_target), .go(go), .abort(abort),
        .busy(busy), .found(found), .exhausted(exhausted), .timeout_err(timeout_err),
        .found_nonce(found_nonce), .found_digest(found_digest),
`ifdef SHA256_SCHED_STATS_EN
        .hash_count(hash_count),
`endif
        .core_rst(core_rst), .core_start(core_start), .core_data_in(core_data_in),
        .core_done(core_done), .core_digest(core_digest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         f;
        logic         e;
        logic         t;
        logic [31:0]  nonce;
        logic         chk_dig;
        logic [255:0] dig;
        logic         rst;
        int           end_cyc;
        int           hashes;
    } res_t;

    res_t         exp_res_q[$];
    logic [511:0] exp_blk_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           core_lat = 10;
    logic [31:0]  salt = 32'd0;

    function automatic logic [255:0] dig_of(input logic [31:0] n, input logic [31:0] s);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = (((n ^ s) + 32'(i)) * 32'h9E37_79B1) ^ (s >> i);
        d[0] = 1'b1;
        return d;
    endfunction

    function automatic logic [511:0] with_nonce(input logic [511:0] b, input logic [31:0] n);
        logic [511:0] r;
        r = b;
        r[NONCE_POS +: 32] = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: done core_lat cycles after start (never when 0), stray done pulses when idle
    initial begin : core_model
        int   cnt;
        logic pend;
        cnt = 0;
        pend = 1'b0;
        core_done = 1'b0;
        core_digest = 256'd0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            for (int i = 0; i < 8; i++) core_digest[i*32 +: 32] = $urandom;
            if (core_rst) begin
                pend = 1'b0;
            end else if (core_start) begin
                pend = 1'b1;
                cnt = core_lat;
            end else if (pend) begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        core_done = 1'b1;
                        core_digest = dig_of(core_data_in[NONCE_POS +: 32], salt);
                        pend = 1'b0;
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                core_done = 1'b1;
            end
        end
    end

    // Monitor: checks every start against the expected block, every search end against the result queue
    initial begin : monitor
        logic         prev_busy;
        logic         prev_rst;
        logic         prev2_rst;
        res_t         r;
        logic [511:0] b;
        prev_busy = 1'b0;
        prev_rst = 1'b0;
        prev2_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                if (exp_blk_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: core_start with no nonce pending at cycle %0d", cyc);
                end else begin
                    b = exp_blk_q.pop_front();
                    chk("core_data_in", core_data_in, b);
                    chk("rst_pulse_before_start", 512'({prev2_rst, prev_rst, core_rst}), 512'(3'b010));
                end
            end
            if (prev_busy && !busy) begin
                if (exp_res_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_end: busy fell with no search pending at cycle %0d", cyc);
                end else begin
                    r = exp_res_q.pop_front();
                    chk("flags_f_e_t", 512'({found, exhausted, timeout_err}), 512'({r.f, r.e, r.t}));
                    chk("found_nonce", 512'(found_nonce), 512'(r.nonce));
                    if (r.chk_dig) chk("found_digest", 512'(found_digest), 512'(r.dig));
                    chk("core_rst_at_end", 512'(core_rst), 512'(r.rst));
                    if (r.end_cyc >= 0) chk("end_cycle", 512'(cyc), 512'(r.end_cyc));
                    chk("all_starts_seen", 512'(exp_blk_q.size()), 512'(0));
`ifdef SHA256_SCHED_STATS_EN
                    chk("hash_count", 512'(hash_count), 512'(r.hashes));
`endif
                end
            end
            prev2_rst = prev_rst;
            prev_rst = core_rst;
            prev_busy = busy;
        end
    end

    task automatic scramble_cfg();
        for (int i = 0; i < 16; i++) cfg_block[i*32 +: 32] = $urandom;
        cfg_nonce_lo = $urandom;
        cfg_nonce_hi = $urandom;
        for (int i = 0; i < 8; i++) cfg_target[i*32 +: 32] = $urandom;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_res_q.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL search_bound: search did not finish within 3000 cycles");
            exp_res_q.delete();
            exp_blk_q.delete();
        end
    endtask

    // One search: reference outcome is pushed at go, then the monitor does the checking
    task automatic run_search(input logic [31:0] lo, input logic [31:0] hi, input logic [255:0] tgt,
                              input int lat, input bit do_abort, input bit go_busy, input bit go_abort);
        res_t         r;
        logic [511:0] blk;
        logic [31:0]  n;
        int           k;
        int           g;
        for (int i = 0; i < 16; i++) blk[i*32 +: 32] = $urandom;
        salt = $urandom;
        core_lat = lat;
        @(negedge clk);
        cfg_block = blk;
        cfg_nonce_lo = lo;
        cfg_nonce_hi = hi;
        cfg_target = tgt;
        go = 1'b1;
        abort = go_abort;
        g = cyc;
        r.f = 1'b0; r.e = 1'b0; r.t = 1'b0; r.chk_dig = 1'b0; r.dig = 256'd0;
        r.rst = 1'b0; r.hashes = 0; r.nonce = lo;
        if (do_abort) begin
            exp_blk_q.push_back(with_nonce(blk, lo));
            r.rst = 1'b1;
            r.end_cyc = g + 3 + lat;
        end else if (lat == 0) begin
            exp_blk_q.push_back(with_nonce(blk, lo));
            r.t = 1'b1;
            r.end_cyc = g + 2 + TIMEOUT;
        end else begin
            n = lo;
            for (k = 1; k <= 64; k++) begin
                exp_blk_q.push_back(with_nonce(blk, n));
                if (dig_of(n, salt) <= tgt) begin
                    r.f = 1'b1;
                    r.chk_dig = 1'b1;
                    r.dig = dig_of(n, salt);
                    break;
                end
                if (n == hi) begin
                    r.e = 1'b1;
                    break;
                end
                n = n + 32'd1;
            end
            r.nonce = n;
            r.hashes = k;
            r.end_cyc = g + 1 + k * (3 + lat);
        end
        exp_res_q.push_back(r);
        @(negedge clk);
        go = 1'b0;
        abort = 1'b0;
        scramble_cfg();
`ifdef SHA256_SCHED_STATS_EN
        chk("hash_count_cleared", 512'(hash_count), 512'(0));
`endif
        if (go_busy) begin
            repeat (2) @(negedge clk);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        if (do_abort) begin
            repeat (lat + 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        wait_idle();
    endtask

    initial begin : stimulus
        logic [255:0] tg;
        logic [31:0]  lo;
        res_t         r;
        reset = 1'b0;
        go = 1'b0;
        abort = 1'b0;
        cfg_block = 512'd0;
        cfg_nonce_lo = 32'd0;
        cfg_nonce_hi = 32'd0;
        cfg_target = 256'd0;
        repeat (3) @(negedge clk);
        chk("reset_status", 512'({busy, found, exhausted, timeout_err, core_start}), 512'(5'd0));
        chk("reset_found_nonce", 512'(found_nonce), 512'(0));
        chk("reset_found_digest", 512'(found_digest), 512'(0));
        chk("reset_core_data_in", core_data_in, 512'd0);
        chk("reset_core_rst", 512'(core_rst), 512'(1));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_core_rst", 512'(core_rst), 512'(0));

        run_search(32'd5, 32'd9, {256{1'b1}}, 70, 1'b0, 1'b0, 1'b0);
        run_search(32'h10, 32'h13, 256'd0, 6, 1'b0, 1'b0, 1'b0);
        run_search(32'hFFFF_FFFE, 32'h0000_0001, 256'd0, 4, 1'b0, 1'b0, 1'b0);
        run_search($urandom, 32'd0, {256{1'b1}}, 0, 1'b0, 1'b0, 1'b0);
        lo = $urandom;
        run_search(lo, lo + 32'd3, {256{1'b1}}, 15, 1'b1, 1'b0, 1'b0);
        lo = $urandom;
        run_search(lo, lo + 32'd2, 256'd0, 3, 1'b0, 1'b0, 1'b0);
        lo = $urandom;
        run_search(lo, lo + 32'd4, 256'd0, 2, 1'b0, 1'b1, 1'b0);
        lo = $urandom;
        run_search(lo, lo, 256'd0, 5, 1'b0, 1'b0, 1'b1);
        run_search(32'd0, 32'd9, 256'd0, 1, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) tg[i*32 +: 32] = $urandom;
            tg[255:224] = tg[255:224] >> $urandom_range(0, 3);
            lo = $urandom;
            run_search(lo, lo + 32'($urandom_range(0, 5)), tg, $urandom_range(1, 12), 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a search
        salt = $urandom;
        core_lat = 70;
        @(negedge clk);
        scramble_cfg();
        go = 1'b1;
        exp_blk_q.push_back(with_nonce(cfg_block, cfg_nonce_lo));
        r.f = 1'b0; r.e = 1'b0; r.t = 1'b0; r.nonce = 32'd0; r.chk_dig = 1'b0; r.dig = 256'd0;
        r.rst = 1'b1; r.end_cyc = -1; r.hashes = 0;
        exp_res_q.push_back(r);
        @(negedge clk);
        go = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midsearch_reset_busy", 512'(busy), 512'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queues_drained", 512'(exp_res_q.size() + exp_blk_q.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_nonce_sched.md
Name: sha256_nonce_sched

Overview:
- Controller that sequences the single-block SHA-256 core across a range of nonces.
- Per nonce: inserts the nonce into a configured 512-bit block, resets the core, pulses start, waits for done, and compares the digest against a 256-bit target.
- Stops on the first digest <= target (hit), on range exhaustion, on abort, or on core timeout.
- Sits between the host register interface and the hashing core.

Parameters:
- NONCE_POS, 0, bit offset of the 32-bit nonce field inside the 512-bit block; legal range 0..480.
- TIMEOUT, 200, max cycles in WAIT without core_done before the timeout error fires.
- TMO_W, 8, width of the timeout counter; requires 2**TMO_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_block  in  512  template block; bits at NONCE_POS are overwritten by the nonce.
- cfg_nonce_lo  in  32  first nonce.
- cfg_nonce_hi  in  32  last nonce, inclusive.
- cfg_target  in  256  hit threshold, unsigned.
- go  in  1  start-search pulse; ignored unless busy=0.
- abort  in  1  stop-search pulse.
- busy  out  1  search in progress.
- found  out  1  last search ended on a hit.
- exhausted  out  1  last search ended with no hit in the range.
- timeout_err  out  1  last search ended on a core timeout.
- found_nonce  out  32  nonce of the hit, or current nonce at any other stop.
- found_digest  out  256  digest of the hit.
- core_rst  out  1  active-high synchronous reset to the core.
- core_start  out  1  start pulse to the core.
- core_data_in  out  512  block presented to the core.
- core_done  in  1  core completion pulse.
- core_digest  in  256  core result, valid in the cycle core_done=1.

Behaviour:
- Reset values: all outputs 0; core_rst=1 while reset is asserted; state IDLE.
- cfg_* are captured into internal registers on an accepted go. Later cfg_* changes have no effect until the next go.
- core_data_in = captured block with bits [NONCE_POS +: 32] replaced by the current nonce. It is registered and stable from CLR through CHECK.
- FSM states:
  - IDLE: on go, capture cfg_*, nonce <= cfg_nonce_lo, clear found/exhausted/timeout_err, busy=1, go to CLR.
  - CLR: core_rst=1 for exactly 1 cycle, then LOAD.
  - LOAD: core_start=1 for exactly 1 cycle, clear the timeout counter, then WAIT.
  - WAIT: core_done=1 -> latch core_digest, go to CHECK. Counter reaches TIMEOUT -> timeout_err=1, go to IDLE.
  - CHECK: 1 cycle; compare latched digest <= captured target, unsigned 256-bit, bit 255 MSB.
    - True -> found=1, found_nonce=nonce, found_digest=digest, IDLE.
    - False and nonce==captured hi -> exhausted=1, IDLE.
    - Otherwise nonce <= nonce+1, CLR.
- Cycles per nonce: 3 + core latency (CLR, LOAD, CHECK).
- Nonce arithmetic is 32-bit. If lo > hi, the range wraps through 0xFFFFFFFF to 0 and ends at hi; the end test is equality only.
- lo == hi: exactly one hash is computed.
- core_done outside WAIT is ignored.
- abort has priority over every other event in the same cycle, including core_done or a hit in CHECK.
  - Any non-IDLE state: next state IDLE, busy=0, no flag set, core_rst=1 for 1 cycle, found_nonce=current nonce.
  - In IDLE: no effect.
- go while busy is ignored. go and abort together in IDLE: go wins.
- busy is 0 in the same cycle the terminal flag becomes 1. Flags hold until the next accepted go.
- Async reset mid-search: return to IDLE immediately, no flag set.

Optional Feature:
- Macro: SHA256_SCHED_STATS_EN.
- Defined: extra output port hash_count (out, 32).
  - Cleared on an accepted go.
  - Incremented once per CHECK cycle, saturating at 0xFFFFFFFF.
  - Holds its value in IDLE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Hit: lo=5, hi=9, target=all-ones; core model returns done 70 cycles after start -> found=1, found_nonce=5, exactly 1 core_start, busy falls 74 cycles after go.
- Exhaustion: lo=0x10, hi=0x13, target=0 with digest never 0 -> exhausted=1, found_nonce=0x13, exactly 4 core_start pulses, each preceded by a 1-cycle core_rst.
- Wrap: lo=0xFFFFFFFE, hi=0x00000001, no hit -> nonces FFFFFFFE, FFFFFFFF, 0, 1 appear at core_data_in[NONCE_POS +: 32], then exhausted=1.
- Timeout: core never asserts done, TIMEOUT=200 -> timeout_err=1 exactly 200 cycles after the core_start cycle; busy=0; found and exhausted stay 0.
- Abort: abort in WAIT in the same cycle as core_done carrying a hit digest -> no flag set, busy=0 next cycle, core_rst pulsed; a second go is then accepted normally.
- Stats (SHA256_SCHED_STATS_EN): exhaustion over lo=0, hi=9 -> hash_count=10; a new go clears it to 0.
